// File: rtl/cache_fill_responder.sv
// cache_fill_responder: memory-side responder for the cache line-fill handshake.
// Accepts a fill request, issues one 4-word burst read, collects the beats into
// a line buffer and replays the line critical-word-first on four consecutive
// cycles, with fill_strobe marking the critical word.
//
// Optional feature macro: FILL_LINEBUF_EN
//   When defined, the last completed line is kept tagged in the buffer; a repeat
//   request to that line is served straight from the buffer, and snooped CPU
//   writes to the line invalidate it.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   fill_req/fill_addr  cache fill request (level) and word address [ADDR_HI:1]
//   fill_strobe         one-cycle pulse with the critical word on fill_data
//   fill_data           16-bit fill word stream
//   mem_req/mem_addr    burst read command and line address, held until mem_ack
//   mem_ack             command accepted
//   mem_rvalid/rdata    read beats, line order 0..3, gaps allowed
//   snoop_we/addr       observed CPU write (used only with FILL_LINEBUF_EN)
module cache_fill_responder #(
    parameter int unsigned ADDR_HI = 25
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fill_req,
    input  logic [ADDR_HI:1]  fill_addr,
    output logic              fill_strobe,
    output logic [15:0]       fill_data,
    output logic              mem_req,
    output logic [ADDR_HI:3]  mem_addr,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic [15:0]       mem_rdata,
    input  logic              snoop_we,
    input  logic [ADDR_HI:1]  snoop_addr
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned WORDS  = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_COLLECT,
        S_STREAM
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [1:0]          k_q, k_d;
    logic [1:0]          crit_q, crit_d;
    logic [ADDR_HI:3]    line_q, line_d;
    logic [DATA_W-1:0]   buf_q [WORDS];
    logic                buf_we;
    logic [1:0]          buf_wa;
    logic                mem_req_d;
    logic [ADDR_HI:3]    mem_addr_d;
    logic                fill_strobe_d;
    logic [DATA_W-1:0]   fill_data_d;
    logic                hit_c;

`ifdef FILL_LINEBUF_EN
    logic [ADDR_HI:3]    tag_q, tag_d;
    logic                valid_q, valid_d;
    logic                pend_q, pend_d;
    logic                snoop_tag_c;
    logic                snoop_line_c;
    logic                snoop_req_c;
    logic                unused_snoop_lo;

    // Snoop comparisons against the buffered tag, the line being fetched, and
    // the line being requested right now.
    assign snoop_tag_c  = snoop_we && (snoop_addr[ADDR_HI:3] == tag_q);
    assign snoop_line_c = snoop_we && (snoop_addr[ADDR_HI:3] == line_q);
    assign snoop_req_c  = snoop_we && (snoop_addr[ADDR_HI:3] == fill_addr[ADDR_HI:3]);
    // A write landing in the same cycle as the request disqualifies the hit.
    assign hit_c = valid_q && !snoop_tag_c && (fill_addr[ADDR_HI:3] == tag_q);
    assign unused_snoop_lo = ^snoop_addr[2:1];
`else
    logic unused_snoop;

    assign hit_c = 1'b0;
    assign unused_snoop = ^{snoop_we, snoop_addr};
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        k_d           = k_q;
        crit_d        = crit_q;
        line_d        = line_q;
        buf_we        = 1'b0;
        buf_wa        = cnt_q;
        mem_req_d     = mem_req;
        mem_addr_d    = mem_addr;
        fill_strobe_d = 1'b0;
        fill_data_d   = fill_data;
`ifdef FILL_LINEBUF_EN
        tag_d   = tag_q;
        pend_d  = pend_q;
        valid_d = valid_q;
        if (snoop_tag_c) begin
            valid_d = 1'b0;
        end
`endif

        case (state_q)
            S_IDLE: begin
                if (fill_req) begin
                    line_d = fill_addr[ADDR_HI:3];
                    crit_d = fill_addr[2:1];
                    if (hit_c) begin
                        state_d       = S_STREAM;
                        k_d           = 2'd0;
                        fill_strobe_d = 1'b1;
                        fill_data_d   = buf_q[fill_addr[2:1]];
                    end else begin
                        state_d    = S_CMD;
                        mem_req_d  = 1'b1;
                        mem_addr_d = fill_addr[ADDR_HI:3];
`ifdef FILL_LINEBUF_EN
                        // Buffer is about to be overwritten.
                        valid_d = 1'b0;
                        pend_d  = snoop_req_c;
`endif
                    end
                end
            end

            S_CMD: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = S_COLLECT;
                    cnt_d     = 2'd0;
                    // Beat 0 may arrive together with the ack.
                    if (mem_rvalid) begin
                        buf_we = 1'b1;
                        buf_wa = 2'd0;
                        cnt_d  = 2'd1;
                    end
                end
`ifdef FILL_LINEBUF_EN
                if (snoop_line_c) begin
                    pend_d = 1'b1;
                end
`endif
            end

            S_COLLECT: begin
                if (mem_rvalid) begin
                    buf_we = 1'b1;
                    buf_wa = cnt_q;
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d       = S_STREAM;
                        k_d           = 2'd0;
                        fill_strobe_d = 1'b1;
                        // Critical word 3 is the beat being written this cycle.
                        fill_data_d   = (crit_q == 2'd3) ? mem_rdata : buf_q[crit_q];
`ifdef FILL_LINEBUF_EN
                        tag_d   = line_q;
                        valid_d = !pend_q && !snoop_line_c;
`endif
                    end
                end
`ifdef FILL_LINEBUF_EN
                if (snoop_line_c) begin
                    pend_d = 1'b1;
                end
`endif
            end

            S_STREAM: begin
                if (k_q == 2'd3) begin
                    state_d = S_IDLE;
                end else begin
                    k_d         = k_q + 2'd1;
                    fill_data_d = buf_q[2'(crit_q + k_q + 2'd1)];
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            k_q         <= 2'd0;
            crit_q      <= 2'd0;
            line_q      <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            fill_strobe <= 1'b0;
            fill_data   <= '0;
`ifdef FILL_LINEBUF_EN
            tag_q       <= '0;
            valid_q     <= 1'b0;
            pend_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            k_q         <= k_d;
            crit_q      <= crit_d;
            line_q      <= line_d;
            mem_req     <= mem_req_d;
            mem_addr    <= mem_addr_d;
            fill_strobe <= fill_strobe_d;
            fill_data   <= fill_data_d;
`ifdef FILL_LINEBUF_EN
            tag_q       <= tag_d;
            valid_q     <= valid_d;
            pend_q      <= pend_d;
`endif
            if (buf_we) begin
                buf_q[buf_wa] <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_cache_fill_responder.sv
// Self-checking bench for cache_fill_responder: directed fills with a scoreboard
// of expected stream words pushed when beats are driven and popped as the line
// is replayed.
module tb_cache_fill_responder;

    localparam int ADDR_HI = 25;

    logic              clk;
    logic              reset;
    logic              fill_req;
    logic [ADDR_HI:1]  fill_addr;
    logic              fill_strobe;
    logic [15:0]       fill_data;
    logic              mem_req;
    logic [ADDR_HI:3]  mem_addr;
    logic              mem_ack;
    logic              mem_rvalid;
    logic [15:0]       mem_rdata;
    logic              snoop_we;
    logic [ADDR_HI:1]  snoop_addr;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    cache_fill_responder #(.ADDR_HI(ADDR_HI)) dut (
        .clk         (clk),
        .reset       (reset),
        .fill_req    (fill_req),
        .fill_addr   (fill_addr),
        .fill_strobe (fill_strobe),
        .fill_data   (fill_data),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .snoop_we    (snoop_we),
        .snoop_addr  (snoop_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag);
        logic [15:0] e;
        chk({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
        chk(tag, 32'(fill_data), 32'(e));
    endtask

    // Strobe visible now: check the four-word stream, then the hold cycle.
    task automatic check_stream(input string tag);
        logic [15:0] last;
        chk({tag, "_strobe0"}, 32'(fill_strobe), 32'd1);
        chk_word({tag, "_w0"});
        fill_req = 1'b0;
        for (int k = 1; k < 4; k++) begin
            step();
            chk({tag, "_strobe_k"}, 32'(fill_strobe), 32'd0);
            chk_word({tag, "_wk"});
        end
        last = fill_data;
        step();
        chk({tag, "_after_strobe"}, 32'(fill_strobe), 32'd0);
        chk({tag, "_after_hold"}, 32'(fill_data), 32'(last));
        chk({tag, "_after_memreq"}, 32'(mem_req), 32'd0);
    endtask

    // Full miss: request, command with ack delay, four beats (optional gaps),
    // stream check. full is the byte-style address; fill_addr = full[ADDR_HI:1].
    task automatic do_miss(input string tag, input logic [ADDR_HI:0] full,
                           input logic [15:0] base, input int ack_delay,
                           input int gap, input bit toggle, input bit ack_beat,
                           input bit snoop);
        logic [ADDR_HI:3] line;
        int crit;
        line = full[ADDR_HI:3];
        crit = int'(full[2:1]);
        fill_req  = 1'b1;
        fill_addr = full[ADDR_HI:1];
        step();
        for (int i = 0; i <= ack_delay; i++) begin
            chk({tag, "_mem_req"}, 32'(mem_req), 32'd1);
            chk({tag, "_mem_addr"}, 32'(mem_addr), 32'(line));
            chk({tag, "_no_strobe_cmd"}, 32'(fill_strobe), 32'd0);
            if (toggle) fill_addr = ADDR_HI'($urandom);
            if (i < ack_delay) step();
        end
        if (!ack_beat) begin
            mem_ack = 1'b1;
            step();
            mem_ack = 1'b0;
            chk({tag, "_mem_req_drop"}, 32'(mem_req), 32'd0);
        end
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(base + 16'((crit + k) % 4));
        end
        for (int i = 0; i < 4; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = base + 16'(i);
            if (i == 0 && ack_beat) mem_ack = 1'b1;
            if (i == 1 && snoop) begin
                snoop_we   = 1'b1;
                snoop_addr = {line, 2'b10};
            end
            step();
            mem_ack    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = 16'hxxxx;
            snoop_we   = 1'b0;
            if (i < 3) begin
                chk({tag, "_no_strobe_beat"}, 32'(fill_strobe), 32'd0);
                for (int g = 0; g < gap; g++) begin
                    step();
                    chk({tag, "_no_strobe_gap"}, 32'(fill_strobe), 32'd0);
                end
            end
        end
        check_stream(tag);
    endtask

    initial begin
        reset      = 1'b1;
        fill_req   = 1'b0;
        fill_addr  = '0;
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        snoop_we   = 1'b0;
        snoop_addr = '0;
        step();
        step();
        reset = 1'b0;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_strobe", 32'(fill_strobe), 32'd0);
        chk("rst_data", 32'(fill_data), 32'd0);
        // Stray beat in IDLE must be ignored.
        mem_rvalid = 1'b1;
        mem_rdata  = 16'hDEAD;
        step();
        mem_rvalid = 1'b0;
        chk("idle_rvalid_strobe", 32'(fill_strobe), 32'd0);
        chk("idle_rvalid_req", 32'(mem_req), 32'd0);

        // Scenario 1: crit 3, ack after 2 cycles, back-to-back beats.
        do_miss("miss1", 26'h0123456, 16'hA000, 2, 0, 1'b0, 1'b0, 1'b0);
        chk("miss1_line_const", 32'(mem_addr), 32'h02468A);

`ifdef FILL_LINEBUF_EN
        // Hit: same line, crit 1, served from the buffer.
        exp_q.push_back(16'hA001);
        exp_q.push_back(16'hA002);
        exp_q.push_back(16'hA003);
        exp_q.push_back(16'hA000);
        fill_req  = 1'b1;
        fill_addr = 25'(26'h0123452 >> 1);
        step();
        chk("hit_no_mem_req", 32'(mem_req), 32'd0);
        check_stream("hit");
        // Snoop invalidates; the repeat request must fetch again.
        snoop_we   = 1'b1;
        snoop_addr = 25'(26'h0123450 >> 1);
        step();
        snoop_we = 1'b0;
        do_miss("snooped", 26'h0123452, 16'hA000, 0, 0, 1'b0, 1'b0, 1'b0);
        // Matching snoop during COLLECT: data still streams, next repeat misses.
        do_miss("snp_col", 26'h0000800, 16'hE000, 1, 0, 1'b0, 1'b0, 1'b1);
        do_miss("snp_rep", 26'h0000806, 16'hE100, 0, 0, 1'b0, 1'b0, 1'b0);
`endif

        // Scenario 2: crit 0, one idle cycle between beats.
        do_miss("gapped", 26'h00ABC08, 16'hB000, 0, 1, 1'b0, 1'b0, 1'b0);

        // Scenario 3: ack after 5 cycles with fill_addr churning, beat 0 with ack.
        do_miss("delay", 26'h3FFFFFA, 16'hC000, 5, 0, 1'b1, 1'b1, 1'b0);

        // Scenario 4: reset during COLLECT after two beats, then stray beats.
        fill_req  = 1'b1;
        fill_addr = 25'(26'h0000004 >> 1);
        step();
        chk("rstc_mem_req", 32'(mem_req), 32'd1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 16'h5550 + 16'(i);
            step();
        end
        mem_rvalid = 1'b0;
        reset    = 1'b1;
        fill_req = 1'b0;
        step();
        reset = 1'b0;
        chk("rstc_mem_req0", 32'(mem_req), 32'd0);
        chk("rstc_mem_addr0", 32'(mem_addr), 32'd0);
        chk("rstc_strobe0", 32'(fill_strobe), 32'd0);
        chk("rstc_data0", 32'(fill_data), 32'd0);
        for (int i = 0; i < 2; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 16'h6660 + 16'(i);
            step();
            chk("rstc_stray_strobe", 32'(fill_strobe), 32'd0);
            chk("rstc_stray_req", 32'(mem_req), 32'd0);
        end
        mem_rvalid = 1'b0;
        step();
        chk("rstc_quiet_strobe", 32'(fill_strobe), 32'd0);
        do_miss("post_rst", 26'h0000004, 16'hD000, 1, 0, 1'b0, 1'b0, 1'b0);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
